// File: rtl/mem_alu_seq.sv
// mem_alu_seq: DEPTH-entry register file with a one-step-per-cycle SUM/DOT/MAX/MIN reduction engine.
// Optional macro MEM_ALU_SAT_EN: SUM/DOT accumulation clamps at all-ones instead of wrapping.
module mem_alu_seq #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  rd_wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  start,
  input  logic [1:0]            op,
  output logic                  busy,
  output logic                  res_valid,
  output logic [RES_WIDTH-1:0]  res_out
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int SUM_W = RES_WIDTH + 1;

  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
  typedef enum logic [1:0] {OP_SUM = 2'b00, OP_DOT = 2'b01, OP_MAX = 2'b10, OP_MIN = 2'b11} op_t;

  state_t                state_r;
  op_t                   op_r;
  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [ADDR_WIDTH-1:0] idx_r;
  logic [RES_WIDTH-1:0]  acc_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  busy_r;
  logic                  res_valid_r;
  logic [RES_WIDTH-1:0]  res_out_r;

  logic [ADDR_WIDTH-1:0]   ev_addr_s;
  logic [ADDR_WIDTH-1:0]   od_addr_s;
  logic [DATA_WIDTH-1:0]   cur_s;
  logic [RES_WIDTH-1:0]    cur_ext_s;
  logic [2*DATA_WIDTH-1:0] prod_s;
  logic [SUM_W-1:0]        addend_s;
  logic [SUM_W-1:0]        sum_s;
  logic                    last_step_s;
  logic [RES_WIDTH-1:0]    acc_next_s;

  assign rd_data   = rd_data_r;
  assign busy      = busy_r;
  assign res_valid = res_valid_r;
  assign res_out   = res_out_r;

  // Datapath for the current RUN step; DOT walks the file in (2i, 2i+1) pairs.
  always_comb begin
    ev_addr_s   = idx_r << 1;
    od_addr_s   = ev_addr_s | ADDR_WIDTH'(1'b1);
    cur_s       = mem_r[idx_r];
    cur_ext_s   = RES_WIDTH'(cur_s);
    prod_s      = {{DATA_WIDTH{1'b0}}, mem_r[ev_addr_s]} * {{DATA_WIDTH{1'b0}}, mem_r[od_addr_s]};
    addend_s    = (op_r == OP_DOT) ? SUM_W'(prod_s) : SUM_W'(cur_s);
    sum_s       = {1'b0, acc_r} + addend_s;
    last_step_s = (op_r == OP_DOT) ? (idx_r == ADDR_WIDTH'(DEPTH/2 - 1))
                                   : (idx_r == ADDR_WIDTH'(DEPTH - 1));
    acc_next_s  = acc_r;
    case (op_r)
      OP_SUM, OP_DOT: begin
`ifdef MEM_ALU_SAT_EN
        // An all-ones acc plus any nonzero addend overflows again, so the clamp is sticky.
        if (sum_s[RES_WIDTH]) begin
          acc_next_s = {RES_WIDTH{1'b1}};
        end else begin
          acc_next_s = sum_s[RES_WIDTH-1:0];
        end
`else
        acc_next_s = sum_s[RES_WIDTH-1:0];
`endif
      end
      OP_MAX: begin
        if (idx_r == {ADDR_WIDTH{1'b0}}) begin
          acc_next_s = cur_ext_s;
        end else if (cur_ext_s > acc_r) begin
          acc_next_s = cur_ext_s;
        end else begin
          acc_next_s = acc_r;
        end
      end
      OP_MIN: begin
        if (idx_r == {ADDR_WIDTH{1'b0}}) begin
          acc_next_s = cur_ext_s;
        end else if (cur_ext_s < acc_r) begin
          acc_next_s = cur_ext_s;
        end else begin
          acc_next_s = acc_r;
        end
      end
      default: acc_next_s = acc_r;
    endcase
  end

  // Register file, bus read port, control FSM and registered result outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
      state_r     <= IDLE;
      op_r        <= OP_SUM;
      idx_r       <= {ADDR_WIDTH{1'b0}};
      acc_r       <= {RES_WIDTH{1'b0}};
      rd_data_r   <= {DATA_WIDTH{1'b0}};
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      res_out_r   <= {RES_WIDTH{1'b0}};
    end else begin
      res_valid_r <= 1'b0;
      if (enable && rd_wr) begin
        rd_data_r <= mem_r[addr];
      end
      case (state_r)
        IDLE: begin
          if (enable && !rd_wr) begin
            mem_r[addr] <= wr_data;
          end
          if (start) begin
            state_r <= RUN;
            op_r    <= op_t'(op);
            acc_r   <= {RES_WIDTH{1'b0}};
            idx_r   <= {ADDR_WIDTH{1'b0}};
            busy_r  <= 1'b1;
          end
        end
        RUN: begin
          acc_r <= acc_next_s;
          idx_r <= idx_r + ADDR_WIDTH'(1'b1);
          if (last_step_s) begin
            state_r     <= DONE;
            res_valid_r <= 1'b1;
            res_out_r   <= acc_next_s;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_alu_seq.sv
// Self-checking bench for mem_alu_seq: scoreboard of expected results, one task per scenario.
module tb_mem_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        rd_wr;
  logic [1:0]  addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data;
  logic        start;
  logic [1:0]  op;
  logic        busy;
  logic        res_valid;
  logic [15:0] res_out;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb_q[$];
  logic [7:0]  shadow [4];

  always #5 clk = ~clk;

  mem_alu_seq #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .RES_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rd_wr(rd_wr), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .start(start), .op(op), .busy(busy),
    .res_valid(res_valid), .res_out(res_out)
  );

  function automatic logic [15:0] model(input logic [1:0] o);
    longint acc;
    acc = 0;
    case (o)
      2'b00, 2'b01: begin
        for (int i = 0; i < ((o == 2'b01) ? 2 : 4); i++) begin
          if (o == 2'b01) acc += longint'(shadow[2*i]) * longint'(shadow[2*i+1]);
          else            acc += longint'(shadow[i]);
`ifdef MEM_ALU_SAT_EN
          if (acc > 65535) acc = 65535;
`else
          acc = acc % 65536;
`endif
        end
      end
      2'b10: begin
        acc = shadow[0];
        for (int i = 1; i < 4; i++) if (shadow[i] > acc) acc = shadow[i];
      end
      default: begin
        acc = shadow[0];
        for (int i = 1; i < 4; i++) if (shadow[i] < acc) acc = shadow[i];
      end
    endcase
    return acc[15:0];
  endfunction

  task automatic do_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    enable = 1'b1; rd_wr = 1'b0; addr = a; wr_data = d;
    @(negedge clk);
    enable = 1'b0;
    shadow[a] = d;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk);
    enable = 1'b1; rd_wr = 1'b1; addr = a;
    @(posedge clk); #1;
    d = rd_data;
    enable = 1'b0;
  endtask

  // mode 0: plain run; mode 1: write addr0 and re-start while busy; mode 2: reset pulse mid-run.
  task automatic run_op(input logic [1:0] o, input int mode, output int lat, output int vcnt,
                        output logic busy1, output logic busy_end, output logic [15:0] res);
    lat = -1; vcnt = 0; busy1 = 1'b0; busy_end = 1'b1; res = 16'h0000;
    @(negedge clk);
    start = 1'b1; op = o;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin start = 1'b0; busy1 = busy; end
      if (res_valid) begin
        vcnt++;
        if (lat < 0) begin lat = k; res = res_out; end
      end
      if (mode == 1 && k == 1) begin
        enable = 1'b1; rd_wr = 1'b0; addr = 2'd0; wr_data = 8'd99; start = 1'b1; op = 2'b01;
      end
      if (mode == 1 && k == 2) begin enable = 1'b0; start = 1'b0; end
      if (mode == 2 && k == 2) reset = 1'b0;
      if (mode == 2 && k == 3) reset = 1'b1;
      busy_end = busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; rd_wr = 1'b0; addr = 2'd0; wr_data = 8'd0; start = 1'b0; op = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
    n_cmp++; if (res_out !== 16'h0000) begin n_err++; $display("FAIL reset_res got=%h exp=0000", res_out); end
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd got=%h exp=00", rd_data); end
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 4; i++) shadow[i] = 8'd0;
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) do_write(2'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++) begin
      do_read(2'(i), d);
      n_cmp++; if (d !== 8'(i + 1)) begin n_err++; $display("FAIL rd_addr%0d got=%0d exp=%0d", i, d, i + 1); end
    end
  endtask

  task automatic test_sum();
    int lat, vcnt; logic b1, be; logic [15:0] res, exp;
    sb_q.push_back(16'd10);
    run_op(2'b00, 0, lat, vcnt, b1, be, res);
    n_cmp++; if (b1 !== 1'b1) begin n_err++; $display("FAIL sum_busy got=%b exp=1", b1); end
    n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL sum_latency got=%0d exp=5", lat); end
    n_cmp++; if (vcnt !== 1) begin n_err++; $display("FAIL sum_valid_pulses got=%0d exp=1", vcnt); end
    n_cmp++; if (be !== 1'b0) begin n_err++; $display("FAIL sum_busy_end got=%b exp=0", be); end
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL sum_result got=%0d exp=%0d", res, exp); end
    n_cmp++; if (res_out !== exp) begin n_err++; $display("FAIL sum_hold got=%0d exp=%0d", res_out, exp); end
  endtask

  task automatic test_ops();
    int lat, vcnt; logic b1, be; logic [15:0] res, exp;
    logic [1:0]  ops  [3] = '{2'b01, 2'b10, 2'b11};
    logic [15:0] exps [3] = '{16'd14, 16'd4, 16'd1};
    int          lats [3] = '{3, 5, 5};
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(exps[i]);
      run_op(ops[i], 0, lat, vcnt, b1, be, res);
      n_cmp++; if (lat !== lats[i]) begin n_err++; $display("FAIL op%0d_latency got=%0d exp=%0d", ops[i], lat, lats[i]); end
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
      n_cmp++; if (res !== exp) begin n_err++; $display("FAIL op%0d_result got=%0d exp=%0d", ops[i], res, exp); end
    end
  endtask

  task automatic test_wrap();
    int lat, vcnt; logic b1, be; logic [15:0] res, exp;
    for (int i = 0; i < 4; i++) do_write(2'(i), 8'd255);
`ifdef MEM_ALU_SAT_EN
    sb_q.push_back(16'hFFFF);
`else
    sb_q.push_back(16'hFC02);
`endif
    run_op(2'b01, 0, lat, vcnt, b1, be, res);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL dot_wrap got=%h exp=%h", res, exp); end
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL dot_wrap_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_busy_ignore();
    int lat, vcnt; logic b1, be; logic [15:0] res, exp; logic [7:0] d;
    for (int i = 0; i < 4; i++) do_write(2'(i), 8'(i + 1));
    sb_q.push_back(16'd10);
    run_op(2'b00, 1, lat, vcnt, b1, be, res);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
    n_cmp++; if (res !== exp) begin n_err++; $display("FAIL busy_result got=%0d exp=%0d", res, exp); end
    n_cmp++; if (vcnt !== 1) begin n_err++; $display("FAIL busy_restart got=%0d pulses exp=1", vcnt); end
    do_read(2'd0, d);
    n_cmp++; if (d !== 8'd1) begin n_err++; $display("FAIL busy_write got=%0d exp=1", d); end
  endtask

  task automatic test_reset_mid_run();
    int lat, vcnt; logic b1, be; logic [15:0] res; logic [7:0] d;
    run_op(2'b00, 2, lat, vcnt, b1, be, res);
    for (int i = 0; i < 4; i++) shadow[i] = 8'd0;
    n_cmp++; if (vcnt !== 0) begin n_err++; $display("FAIL abort_valid got=%0d pulses exp=0", vcnt); end
    n_cmp++; if (be !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", be); end
    n_cmp++; if (res_out !== 16'h0000) begin n_err++; $display("FAIL abort_res got=%h exp=0000", res_out); end
    for (int i = 0; i < 4; i++) begin
      do_read(2'(i), d);
      n_cmp++; if (d !== 8'd0) begin n_err++; $display("FAIL abort_mem%0d got=%0d exp=0", i, d); end
    end
  endtask

  task automatic test_back_to_back();
    int lat, vcnt; logic b1, be; logic [15:0] res, exp; logic [1:0] o;
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 4; i++) do_write(2'(i), 8'($urandom_range(0, 255)));
      o = 2'($urandom_range(0, 3));
      sb_q.push_back(model(o));
      run_op(o, 0, lat, vcnt, b1, be, res);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 16'hxxxx;
      n_cmp++; if (res !== exp) begin n_err++; $display("FAIL rand%0d_op%0d got=%0d exp=%0d", n, o, res, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_sum();
    test_ops();
    test_wrap();
    test_busy_ignore();
    test_reset_mid_run();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
